// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD write controller with power-on init sequence.
// One down-counter times every bus phase and execution wait.
module lcd_ctrl #(
    parameter bit INIT_EN     = 1'b1,
    parameter int INIT_CYC    = 750000,
    parameter int SETUP_CYC   = 2,
    parameter int EN_HIGH_CYC = 12,
    parameter int HOLD_CYC    = 1,
    parameter int EXEC_CYC    = 2000,
    parameter int CLEAR_CYC   = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_valid,
    input  logic [31:0] i_wr_data,
    output logic        o_wr_ready,
    output logic [31:0] o_status,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);

    localparam int M1 = (INIT_CYC > CLEAR_CYC) ? INIT_CYC : CLEAR_CYC;
    localparam int M2 = (EXEC_CYC > EN_HIGH_CYC) ? EXEC_CYC : EN_HIGH_CYC;
    localparam int M3 = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int M4 = (M1 > M2) ? M1 : M2;
    localparam int MAXC = (M4 > M3) ? M4 : M3;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] L_INIT  = CW'(INIT_CYC - 1);
    localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] L_EN    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] L_EXEC  = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] L_CLEAR = CW'(CLEAR_CYC - 1);

    typedef enum logic [2:0] {
        INIT_WAIT, SETUP, PULSE, HOLD, EXEC, IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          initing;
    logic          done;
    logic          run;
    logic          rs;
    logic [7:0]    db;
    logic          is_clear;
    logic          unused_bits;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    // Clear/home commands need the long execution wait
    assign is_clear = !rs && (db[7:2] == 6'd0) && (db[1:0] != 2'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= INIT_EN ? INIT_WAIT : IDLE;
            cnt     <= L_INIT;
            idx     <= 2'd0;
            initing <= INIT_EN;
            done    <= 1'b0;
            run     <= 1'b0;
            rs      <= 1'b0;
            db      <= 8'h00;
        end else begin
            run <= 1'b1;
            case (state)
                INIT_WAIT: begin
                    if (cnt == '0) begin
                        rs    <= 1'b0;
                        db    <= init_byte(2'd0);
                        idx   <= 2'd0;
                        cnt   <= L_SETUP;
                        state <= SETUP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (i_wr_valid) begin
                        rs    <= i_wr_data[9];
                        db    <= i_wr_data[7:0];
                        cnt   <= L_SETUP;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        cnt   <= L_EN;
                        state <= PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        cnt   <= L_HOLD;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= is_clear ? L_CLEAR : L_EXEC;
                        state <= EXEC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (initing && idx != 2'd3) begin
                        idx   <= idx + 2'd1;
                        rs    <= 1'b0;
                        db    <= init_byte(idx + 2'd1);
                        cnt   <= L_SETUP;
                        state <= SETUP;
                    end else begin
                        initing <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_wr_ready = (state == IDLE);
    assign o_status   = {30'b0, INIT_EN ? done : 1'b1,
                         run && (state != IDLE)};
    assign o_lcd_on   = run;
    assign o_lcd_en   = (state == PULSE);
    assign o_lcd_rs   = rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = db;

    assign unused_bits = ^{i_wr_data[31:10], i_wr_data[8]};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: transaction-level timing model plus directed
// literal checks, then randomized writes and resets.
module tb_lcd_ctrl;

    localparam int SU = 2, EH = 3, HO = 1, EX = 5, CL = 20, IC = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, vld;
    logic [31:0] wd;
    logic        rdy[2], en[2], rs[2], rw[2], on[2];
    logic [31:0] st[2];
    logic [7:0]  db[2];

    lcd_ctrl #(.INIT_EN(1'b1), .INIT_CYC(IC), .SETUP_CYC(SU),
               .EN_HIGH_CYC(EH), .HOLD_CYC(HO), .EXEC_CYC(EX),
               .CLEAR_CYC(CL)) u_init (
        .i_clk(clk), .i_reset(rst), .i_wr_valid(vld), .i_wr_data(wd),
        .o_wr_ready(rdy[0]), .o_status(st[0]), .o_lcd_on(on[0]),
        .o_lcd_en(en[0]), .o_lcd_rs(rs[0]), .o_lcd_rw(rw[0]),
        .o_lcd_data(db[0]));

    lcd_ctrl #(.INIT_EN(1'b0), .INIT_CYC(IC), .SETUP_CYC(SU),
               .EN_HIGH_CYC(EH), .HOLD_CYC(HO), .EXEC_CYC(EX),
               .CLEAR_CYC(CL)) u_noinit (
        .i_clk(clk), .i_reset(rst), .i_wr_valid(vld), .i_wr_data(wd),
        .o_wr_ready(rdy[1]), .o_status(st[1]), .o_lcd_on(on[1]),
        .o_lcd_en(en[1]), .o_lcd_rs(rs[1]), .o_lcd_rw(rw[1]),
        .o_lcd_data(db[1]));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mv = 1'b0;

    task automatic chk(input string nm, input int m,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h",
                     nm, m, cyc, got, exp);
        end
    endtask

    // Model: each write is a transaction with a start edge and length
    bit         m_on[2], m_done[2], m_act[2], m_iw[2], m_ip[2];
    int         m_ts[2], m_len[2], m_wend[2], m_nidx[2];
    bit         m_rs[2];
    logic [7:0] m_db[2];
    logic [7:0] ib[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    function automatic int txlen(input bit r, input logic [7:0] d);
        return SU + EH + HO + ((!r && d >= 1 && d <= 3) ? CL : EX);
    endfunction

    task automatic start(input int m, input bit r, input logic [7:0] d);
        m_act[m] = 1'b1;
        m_ts[m]  = cyc;
        m_rs[m]  = r;
        m_db[m]  = d;
        m_len[m] = txlen(r, d);
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_on[m]   = 1'b0;
                m_done[m] = 1'b0;
                m_act[m]  = 1'b0;
                m_rs[m]   = 1'b0;
                m_db[m]   = 8'h00;
                m_iw[m]   = (m == 0);
                m_ip[m]   = (m == 0);
                m_wend[m] = cyc + IC;
                m_nidx[m] = 0;
            end else begin
                m_on[m] = 1'b1;
                if (m_iw[m]) begin
                    if (cyc == m_wend[m]) begin
                        m_iw[m] = 1'b0;
                        start(m, 1'b0, ib[0]);
                        m_nidx[m] = 1;
                    end
                end else if (m_act[m]) begin
                    if (cyc == m_ts[m] + m_len[m]) begin
                        if (m_ip[m] && m_nidx[m] < 4) begin
                            start(m, 1'b0, ib[m_nidx[m]]);
                            m_nidx[m]++;
                        end else begin
                            m_act[m]  = 1'b0;
                            m_ip[m]   = 1'b0;
                            m_done[m] = 1'b1;
                        end
                    end
                end else if (vld) begin
                    start(m, wd[9], wd[7:0]);
                end
            end
        end
        if (rst) mv = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (mv) begin
            for (int m = 0; m < 2; m++) begin
                int  k;
                bit  e_en, e_busy, e_done;
                k      = cyc - m_ts[m];
                e_en   = m_act[m] && k >= SU && k < SU + EH;
                e_busy = m_on[m] && (m_act[m] || m_iw[m]);
                e_done = (m == 0) ? m_done[m] : 1'b1;
                chk("ready", m, 32'(rdy[m]), 32'(!m_act[m] && !m_iw[m]));
                chk("status", m, st[m], {30'b0, e_done, e_busy});
                chk("lcd_on", m, 32'(on[m]), 32'(m_on[m]));
                chk("lcd_en", m, 32'(en[m]), 32'(e_en));
                chk("lcd_rs", m, 32'(rs[m]), 32'(m_rs[m]));
                chk("lcd_rw", m, 32'(rw[m]), 32'd0);
                chk("lcd_data", m, 32'(db[m]), 32'(m_db[m]));
            end
        end
    end

    int rw_seen = 0;

    task automatic measure(input logic [31:0] d, input int mode,
                           output int first_en, output int en_cnt,
                           output int rdy_k, output int busy_cnt,
                           output int npulse, output int rise2,
                           output logic [7:0] last_db, output bit last_rs,
                           output logic [7:0] end_db);
        bit pe = 1'b0;
        first_en = -1; en_cnt = 0; rdy_k = -1; busy_cnt = 0;
        npulse = 0; rise2 = -1; last_db = 8'h00; last_rs = 1'b0;
        vld = 1'b1;
        wd  = d;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #2;
            if (en[1]) en_cnt++;
            if (en[1] && !pe) begin
                npulse++;
                if (npulse == 1) first_en = k;
                else rise2 = k;
                last_db = db[1];
                last_rs = rs[1];
            end
            pe = en[1];
            if (rdy_k < 0 && rdy[1]) rdy_k = k;
            else if (mode == 2 && rdy_k >= 0 && k == rdy_k + 1) vld = 1'b0;
            if (st[1][0]) busy_cnt++;
            if (rw[1]) rw_seen++;
            if (k == 0 && mode != 2) vld = 1'b0;
            if (k == 0 && mode == 2) wd = 32'h0000_0242;
            if (k == 3 && mode == 1) begin
                vld = 1'b1;
                wd  = 32'h0000_0249;
            end
            if (k == 4 && mode == 1) vld = 1'b0;
        end
        vld = 1'b0;
        end_db = db[1];
    endtask

    initial begin
        int fe, ec, rk, bc, np, r2, k_rdy, nb;
        logic [7:0] ldb, edb;
        logic [31:0] bytes;
        bit lrs, prev, rs_any;

        rst = 1'b1; vld = 1'b0; wd = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_status", 0, st[0], 32'h0);
        chk("rst_ready", 0, 32'(rdy[0]), 32'd0);
        chk("rst_lcd_on", 0, 32'(on[0]), 32'd0);
        chk("rst_status", 1, st[1], 32'h2);
        chk("rst_ready", 1, 32'(rdy[1]), 32'd1);
        rst = 1'b0;

        k_rdy = -1; nb = 0; bytes = 32'h0; prev = 1'b0; rs_any = 1'b0;
        for (int k = 1; k <= 100 && k_rdy < 0; k++) begin
            @(posedge clk);
            #2;
            if (en[0] && !prev) begin
                nb++;
                bytes  = {bytes[23:0], db[0]};
                rs_any = rs_any | rs[0];
            end
            prev = en[0];
            if (rdy[0]) k_rdy = k;
        end
        chk("init_ready_k", 0, 32'(k_rdy), 32'd69);
        chk("init_npulses", 0, 32'(nb), 32'd4);
        chk("init_bytes", 0, bytes, 32'h380C_0106);
        chk("init_rs", 0, 32'(rs_any), 32'd0);
        chk("init_status", 0, st[0], 32'h2);

        measure(32'h0000_0241, 0, fe, ec, rk, bc, np, r2, ldb, lrs, edb);
        chk("data_en_start", 1, 32'(fe), 32'd2);
        chk("data_en_width", 1, 32'(ec), 32'd3);
        chk("data_ready_low", 1, 32'(rk), 32'd11);
        chk("data_db", 1, 32'(ldb), 32'h41);
        chk("data_rs", 1, 32'(lrs), 32'd1);

        measure(32'h0000_0001, 0, fe, ec, rk, bc, np, r2, ldb, lrs, edb);
        chk("clear_ready_low", 1, 32'(rk), 32'd26);
        chk("clear_busy_cnt", 1, 32'(bc), 32'd26);
        chk("clear_db", 1, 32'(ldb), 32'h01);
        chk("clear_rs", 1, 32'(lrs), 32'd0);

        measure(32'h0000_0248, 1, fe, ec, rk, bc, np, r2, ldb, lrs, edb);
        chk("ignore_npulse", 1, 32'(np), 32'd1);
        chk("ignore_db", 1, 32'(edb), 32'h48);
        chk("ignore_ready_low", 1, 32'(rk), 32'd11);

        measure(32'h0000_0241, 2, fe, ec, rk, bc, np, r2, ldb, lrs, edb);
        chk("b2b_ready_low", 1, 32'(rk), 32'd11);
        chk("b2b_npulse", 1, 32'(np), 32'd2);
        chk("b2b_rise2", 1, 32'(r2), 32'(rk + 1 + SU));
        chk("b2b_db", 1, 32'(ldb), 32'h42);
        chk("rw_never_high", 1, 32'(rw_seen), 32'd0);

        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        k_rdy = -1;
        for (int k = 1; k <= 40 && k_rdy < 0; k++) begin
            @(posedge clk);
            #2;
            if (en[0]) k_rdy = k;
        end
        chk("midrst_reach_pulse", 0, 32'(k_rdy), 32'd12);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("midrst_en", 0, 32'(en[0]), 32'd0);
        chk("midrst_db", 0, 32'(db[0]), 32'h00);
        chk("midrst_on", 0, 32'(on[0]), 32'd0);
        rst = 1'b0;
        k_rdy = -1;
        for (int k = 1; k <= 40 && k_rdy < 0; k++) begin
            @(posedge clk);
            #2;
            if (en[0]) k_rdy = k;
        end
        chk("restart_en_k", 0, 32'(k_rdy), 32'd12);
        chk("restart_db", 0, 32'(db[0]), 32'h38);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            rst = ($urandom_range(0, 399) < 2) ||
                  (rst && $urandom_range(0, 1) == 0);
            vld = ($urandom_range(0, 9) < 4);
            wd  = $urandom;
            if ($urandom_range(0, 3) == 0) wd[7:0] = 8'($urandom_range(0, 4));
        end
        rst = 1'b0;
        vld = 1'b0;
        repeat (120) @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
